// File: rtl/riscv_pkg.sv
// Shared register-file constants and types: default data width, register count
// and the address/data typedefs used across the integer register file.
package riscv_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int NREGS_DEFAULT = 32;
    localparam int REG_AW        = $clog2(NREGS_DEFAULT);

    typedef logic [REG_AW-1:0]       reg_addr_t;
    typedef logic [XLEN_DEFAULT-1:0] reg_data_t;

    // Register 0 is hardwired; this decides whether an address names real storage.
    function automatic logic addr_is_live(input reg_addr_t addr);
        return addr != '0;
    endfunction

endpackage

// File: rtl/regfile_bypass_mux.sv
// One read port's forwarding/priority selector: picks the stored value or the
// highest-index same-cycle write, and derives the port's busy indication.
module regfile_bypass_mux #(
    parameter int XLEN   = 32,
    parameter int AW     = 5,
    parameter int NUM_WR = 2,
    parameter int BYPASS = 1
) (
    input  logic [AW-1:0]                  rd_addr,
    input  logic [XLEN-1:0]                stored_data,
    input  logic                           stored_busy,
    input  logic [NUM_WR-1:0]              wr_act,
    input  logic [NUM_WR-1:0][AW-1:0]      wr_addr,
    input  logic [NUM_WR-1:0][XLEN-1:0]    wr_data,
    output logic [XLEN-1:0]                rd_data,
    output logic                           rd_busy
);

    // Ascending scan so a later (higher-index) matching port overrides earlier ones;
    // a forwarded value means the producer has arrived, so busy is masked.
    always_comb begin
        rd_data = stored_data;
        rd_busy = stored_busy;
        if (BYPASS != 0) begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_act[j] && (wr_addr[j] == rd_addr)) begin
                    rd_data = wr_data[j];
                    rd_busy = 1'b0;
                end
            end
        end
        if (rd_addr == '0) begin
            rd_data = '0;
            rd_busy = 1'b0;
        end
    end

endmodule

// File: rtl/register_file_mp.sv
// Multi-ported integer register file with per-register busy (scoreboard) bits,
// optional write-to-read forwarding and a registered same-address write flag.
module register_file_mp
    import riscv_pkg::*;
#(
    parameter  int XLEN   = XLEN_DEFAULT,
    parameter  int NREGS  = NREGS_DEFAULT,
    parameter  int NUM_RD = 2,
    parameter  int NUM_WR = 2,
    parameter  int BYPASS = 1,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_RD-1:0][AW-1:0]      rd_addr,
    output logic [NUM_RD-1:0][XLEN-1:0]    rd_data,
    output logic [NUM_RD-1:0]              rd_busy,
    input  logic [NUM_WR-1:0]              wr_en,
    input  logic [NUM_WR-1:0][AW-1:0]      wr_addr,
    input  logic [NUM_WR-1:0][XLEN-1:0]    wr_data,
    input  logic                           busy_set_en,
    input  logic [AW-1:0]                  busy_set_addr,
    output logic                           wr_conflict
);

    logic [XLEN-1:0]   regs_q [NREGS];
    logic [NREGS-1:0]  busy_q;
    logic [NUM_WR-1:0] wr_act;
    logic              conflict_now;
    logic              busy_set_act;

    // Gating with rst_n keeps writes out of storage and out of the forwarding path
    // while reset is held, including a write that was in flight when it asserted.
    always_comb begin
        wr_act = '0;
        for (int j = 0; j < NUM_WR; j++) begin
            wr_act[j] = wr_en[j] && rst_n && (wr_addr[j] != '0);
        end
        busy_set_act = busy_set_en && rst_n && (busy_set_addr != '0);
    end

    always_comb begin
        conflict_now = 1'b0;
        for (int a = 0; a < NUM_WR; a++) begin
            for (int b = a + 1; b < NUM_WR; b++) begin
                if (wr_act[a] && wr_act[b] && (wr_addr[a] == wr_addr[b])) begin
                    conflict_now = 1'b1;
                end
            end
        end
    end

    // Later loop iterations take precedence in the non-blocking updates, which gives
    // the higher-index port the win; the busy-set comes last so it beats a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
            busy_q      <= '0;
            wr_conflict <= 1'b0;
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_act[j]) begin
                    regs_q[wr_addr[j]] <= wr_data[j];
                    busy_q[wr_addr[j]] <= 1'b0;
                end
            end
            if (busy_set_act) begin
                busy_q[busy_set_addr] <= 1'b1;
            end
            wr_conflict <= conflict_now;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        regfile_bypass_mux #(
            .XLEN   (XLEN),
            .AW     (AW),
            .NUM_WR (NUM_WR),
            .BYPASS (BYPASS)
        ) u_mux (
            .rd_addr     (rd_addr[i]),
            .stored_data (regs_q[rd_addr[i]]),
            .stored_busy (busy_q[rd_addr[i]]),
            .wr_act      (wr_act),
            .wr_addr     (wr_addr),
            .wr_data     (wr_data),
            .rd_data     (rd_data[i]),
            .rd_busy     (rd_busy[i])
        );
    end

endmodule

// File: doc/register_file_mp.md
REGISTER_FILE_MP -- requirements
Module: register_file_mp

Interface
REQ-001 Parameter XLEN, 32, data width in bits.
REQ-002 Parameter NREGS, 32, number of architectural registers; power of two, at least 2.
REQ-003 Parameter NUM_RD, 2, number of read ports, 1..4.
REQ-004 Parameter NUM_WR, 2, number of write ports, 1..2.
REQ-005 Parameter BYPASS, 1, write-to-read forwarding enable (0/1).
REQ-006 The block SHALL use one clock, clk, and an asynchronous active-low reset, rst_n.
REQ-007 Port list SHALL be, in this order:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- rd_addr  in  NUM_RD x AW  read addresses, AW = clog2(NREGS).
- rd_data  out  NUM_RD x XLEN  read data.
- rd_busy  out  NUM_RD  read register has a pending producer.
- wr_en  in  NUM_WR  write enables.
- wr_addr  in  NUM_WR x AW  write addresses.
- wr_data  in  NUM_WR x XLEN  write data.
- busy_set_en  in  1  mark a destination register pending (issue).
- busy_set_addr  in  AW  register to mark pending.
- wr_conflict  out  1  registered flag: two write ports hit the same nonzero address.

Function
REQ-008 Register 0 SHALL read as zero on every port; writes to it and busy-sets of it SHALL be ignored.
REQ-009 Reads SHALL be combinational from rd_addr to rd_data and rd_busy.
REQ-010 Writes SHALL commit on the rising edge of clk when wr_en[j]=1 and wr_addr[j]!=0.
REQ-011 When two ports write the same address in one cycle, the higher-index port SHALL win.
REQ-012 On a same-address write, wr_conflict SHALL be 1 in the following cycle only.
REQ-013 With BYPASS=1, a read whose address matches an active nonzero write SHALL return that wr_data in the same cycle; when several writes match, the highest-index port SHALL supply the data.
REQ-014 With BYPASS=0, a read SHALL return the stored value, so a new write is visible only from the next cycle.
REQ-015 Busy bit: set at the clock edge by busy_set_en; cleared at the clock edge by any committed write to that address.
REQ-016 When a busy-set and a write target the same address in one cycle, the set SHALL win and the bit SHALL end at 1.
REQ-017 rd_busy[i] SHALL be busy[rd_addr[i]], masked to 0 when BYPASS=1 and a same-cycle write matches rd_addr[i]; it SHALL always be 0 for register 0.
REQ-018 Reads SHALL have no port-count limit beyond NUM_RD, and every read port SHALL be independent.

Reset
REQ-019 While rst_n=0, all registers SHALL be 0, all busy bits 0 and wr_conflict 0, asynchronously.
REQ-020 Writes and busy-sets SHALL be ignored while rst_n=0.
REQ-021 Reset asserted mid-operation SHALL discard any in-flight write in that cycle.

Structure
REQ-022 The shared package (riscv_pkg) SHALL hold the default XLEN/NREGS constants and the reg_addr_t and reg_data_t typedefs.
REQ-023 Forwarding and priority selection SHALL be a sub-module, regfile_bypass_mux, instantiated once per read port.

Verification
REQ-024 The bench SHALL cover these scenarios:
- Reset: rst_n=0 for 100 ns, then read every address on all ports -> all rd_data=0, all rd_busy=0.
- Write/bypass: wr_en[0]=1, wr_addr=5, data=0xDEADBEEF, rd_addr[0]=5 in the same cycle -> BYPASS=1 returns 0xDEADBEEF immediately; BYPASS=0 returns 0 in that cycle and 0xDEADBEEF in the next.
- Conflict: port0 writes x7=0x11 and port1 writes x7=0x22 -> x7 reads 0x22 and wr_conflict=1 for exactly one cycle.
- x0: write x0=0xFFFFFFFF and busy-set x0 -> x0 reads 0 and rd_busy=0 on all ports.
- Busy: busy-set x3, then rd_addr=3 -> rd_busy=1; write x3=0x5 -> rd_busy=0 (same cycle if BYPASS=1); set and write x3 in the same cycle -> rd_busy=1 afterwards.
- Reset mid-write: assert rst_n=0 while writing x9=0xA5 -> x9 reads 0 after reset is released.
